// File: rtl/spm_pkg.sv
// Shared types and constants for the product BCD reader.
// Defaults, FSM state encoding, double-dabble constants, counter sizing.
package spm_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int DIGITS_DEF = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [3:0] BCD_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADD    = 4'd3;

    // Iteration counter must hold 0..w.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_w(PROD_W_DEF);

endpackage

// File: rtl/dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
// Ports: word = {bcd, mag} in, next_word = {bcd, mag} after one step.
module dabble_step
    import spm_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic [4*DIGITS+PROD_W-1:0] word,
    output logic [4*DIGITS+PROD_W-1:0] next_word
);

    localparam int BW = 4 * DIGITS;

    logic [BW-1:0] bcd_in;
    logic [BW-1:0] bcd_adj;

    assign bcd_in = word[BW+PROD_W-1 -: BW];

    always_comb begin
        bcd_adj = bcd_in;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[4*d +: 4] >= BCD_THRESH) begin
                bcd_adj[4*d +: 4] = bcd_in[4*d +: 4] + BCD_ADD;
            end
        end
        next_word = {bcd_adj, word[PROD_W-1:0]} << 1;
    end

endmodule

// File: rtl/product_bcd_reader.sv
// Captures the signed product on a rising done flag and converts it to
// sign + BCD digits, one double-dabble iteration per clock.
// Ports: clk_out_i, rst_ni (async low), done_i, product_i, clear_i in;
//        sign_o, bcd_o, valid_o, busy_o registered out.
module product_bcd_reader
    import spm_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk_out_i,
    input  logic                  rst_ni,
    input  logic                  done_i,
    input  logic [PROD_W-1:0]     product_i,
    input  logic                  clear_i,
    output logic                  sign_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  valid_o,
    output logic                  busy_o
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = cnt_w(PROD_W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PROD_W - 1);

    state_t              state_q, state_d;
    logic                done_q;
    logic [PROD_W-1:0]   mag_q, mag_d;
    logic [BW-1:0]       bcd_w_q, bcd_w_d;
    logic                sign_w_q, sign_w_d;
    logic [CW-1:0]       count_q, count_d;
    logic                sign_d;
    logic [BW-1:0]       bcd_d;
    logic                valid_d;
    logic                busy_d;
    logic                start;
    logic [BW+PROD_W-1:0] step_out;

    dabble_step #(
        .PROD_W (PROD_W),
        .DIGITS (DIGITS)
    ) u_step (
        .word      ({bcd_w_q, mag_q}),
        .next_word (step_out)
    );

    // Only a 0->1 transition of the level done flag starts a conversion.
    assign start = done_i & ~done_q;

    always_ff @(posedge clk_out_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            mag_q    <= '0;
            bcd_w_q  <= '0;
            sign_w_q <= 1'b0;
            count_q  <= '0;
            sign_o   <= 1'b0;
            bcd_o    <= '0;
            valid_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_i;
            mag_q    <= mag_d;
            bcd_w_q  <= bcd_w_d;
            sign_w_q <= sign_w_d;
            count_q  <= count_d;
            sign_o   <= sign_d;
            bcd_o    <= bcd_d;
            valid_o  <= valid_d;
            busy_o   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        bcd_w_d  = bcd_w_q;
        sign_w_d = sign_w_q;
        count_d  = count_q;
        sign_d   = sign_o;
        bcd_d    = bcd_o;
        valid_d  = valid_o;
        busy_d   = busy_o;

        case (state_q)
            IDLE: begin
                if (!clear_i && start) begin
                    state_d  = CONVERT;
                    // Unsigned magnitude: the most negative value maps to
                    // 2^(PROD_W-1), which still fits PROD_W bits.
                    mag_d    = product_i[PROD_W-1] ? -product_i
                                                   : product_i;
                    sign_w_d = product_i[PROD_W-1];
                    bcd_w_d  = '0;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    valid_d  = 1'b0;
                end
            end
            CONVERT: begin
                if (clear_i) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                end else begin
                    {bcd_w_d, mag_d} = step_out;
                    count_d = count_q + CNT_ONE;
                    if (count_q == CNT_LAST) begin
                        state_d = HOLD;
                        bcd_d   = step_out[BW+PROD_W-1 -: BW];
                        sign_d  = sign_w_q;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (clear_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_product_bcd_reader.sv
// Self-checking bench for product_bcd_reader.
// Vector table + scoreboard queue, plus abort, level-done and reset cases.
module tb_product_bcd_reader;

    logic        clk;
    logic        rst_n;
    logic        done;
    logic [15:0] product;
    logic        clear;
    logic        sign;
    logic [19:0] bcd;
    logic        valid;
    logic        busy;

    product_bcd_reader dut (
        .clk_out_i (clk),
        .rst_ni    (rst_n),
        .done_i    (done),
        .product_i (product),
        .clear_i   (clear),
        .sign_o    (sign),
        .bcd_o     (bcd),
        .valid_o   (valid),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] prod;
        logic        sgn;
        logic [19:0] bcd;
    } vec_t;

    typedef struct packed {
        logic        sgn;
        logic [19:0] bcd;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[8];

    int checks = 0;
    int errors = 0;
    logic        last_sign = 1'b0;
    logic [19:0] last_bcd  = 20'h0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [19:0] model_bcd(input logic [15:0] p);
        int m;
        logic [19:0] r;
        m = p[15] ? (65536 - int'(p)) : int'(p);
        r = '0;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Re-arm with clear, drop done, then raise done with a new product.
    task automatic start_conv(input logic [15:0] p, input logic es,
                              input logic [19:0] eb, input bit push);
        exp_t e;
        @(posedge clk); #1;
        clear = 1'b1;
        done  = 1'b0;
        @(posedge clk); #1;
        clear   = 1'b0;
        product = p;
        if (push) begin
            e.sgn = es;
            e.bcd = eb;
            sbq.push_back(e);
        end
        done = 1'b1;
    endtask

    task automatic wait_result(input string nm);
        int n = 0;
        bit busy_ok = 1'b1;
        bit stable_ok = 1'b1;
        exp_t e;
        while (!valid && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (!valid) begin
                if (!busy) busy_ok = 1'b0;
                if (bcd !== last_bcd || sign !== last_sign)
                    stable_ok = 1'b0;
            end
        end
        check({nm, " latency"}, n, 17);
        check({nm, " busy during convert"}, 32'(busy_ok), 1);
        check({nm, " outputs stable during convert"}, 32'(stable_ok), 1);
        check({nm, " busy at valid"}, 32'(busy), 0);
        if (sbq.size() == 0) begin
            check({nm, " scoreboard empty"}, 1, 0);
        end else begin
            e = sbq.pop_front();
            check({nm, " sign"}, 32'(sign), 32'(e.sgn));
            check({nm, " bcd"}, 32'(bcd), 32'(e.bcd));
            last_sign = e.sgn;
            last_bcd  = e.bcd;
        end
    endtask

    initial begin
        bit seen;
        logic [15:0] rp;

        vecs[0] = '{"p4000", 16'h4000, 1'b0, 20'h16384};
        vecs[1] = '{"pC080", 16'hC080, 1'b1, 20'h16256};
        vecs[2] = '{"pFFFF", 16'hFFFF, 1'b1, 20'h00001};
        vecs[3] = '{"p8000", 16'h8000, 1'b1, 20'h32768};
        vecs[4] = '{"p0000", 16'h0000, 1'b0, 20'h00000};
        for (int i = 5; i < 8; i++) begin
            rp = 16'($urandom);
            vecs[i] = '{$sformatf("rand%0d", i), rp, rp[15], model_bcd(rp)};
        end

        rst_n   = 1'b0;
        done    = 1'b0;
        clear   = 1'b0;
        product = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset sign", 32'(sign), 0);
        check("reset bcd", 32'(bcd), 0);
        check("reset valid", 32'(valid), 0);
        check("reset busy", 32'(busy), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            start_conv(vecs[i].prod, vecs[i].sgn, vecs[i].bcd, 1'b1);
            wait_result(vecs[i].name);
        end

        // done_i stays high through HOLD and after clear
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (!valid || busy) seen = 1'b1;
        end
        check("hold stays valid", 32'(seen), 0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear drops valid", 32'(valid), 0);
        check("clear keeps bcd", 32'(bcd), 32'(last_bcd));
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (valid || busy) seen = 1'b1;
        end
        check("level done no retrigger", 32'(seen), 0);

        // abort on the 8th CONVERT cycle
        start_conv(16'h0019, 1'b0, 20'h0, 1'b0);
        @(posedge clk); #1;
        repeat (7) begin
            @(posedge clk); #1;
        end
        check("abort busy before", 32'(busy), 1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("abort busy", 32'(busy), 0);
        check("abort valid", 32'(valid), 0);
        check("abort keeps bcd", 32'(bcd), 32'(last_bcd));
        check("abort keeps sign", 32'(sign), 32'(last_sign));
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (valid || busy) seen = 1'b1;
        end
        check("abort no valid", 32'(seen), 0);
        start_conv(16'h0019, 1'b0, 20'h00025, 1'b1);
        wait_result("p0019");

        // async reset mid-CONVERT
        start_conv(16'hC080, 1'b1, 20'h16256, 1'b1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("pre reset busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        done  = 1'b0;
        #1;
        check("rst convert busy", 32'(busy), 0);
        check("rst convert valid", 32'(valid), 0);
        check("rst convert bcd", 32'(bcd), 0);
        check("rst convert sign", 32'(sign), 0);
        rst_n = 1'b1;
        sbq.delete();
        last_sign = 1'b0;
        last_bcd  = 20'h0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (valid || busy) seen = 1'b1;
        end
        check("idle after reset", 32'(seen), 0);

        // async reset in HOLD
        start_conv(16'h8000, 1'b1, 20'h32768, 1'b1);
        wait_result("p8000 pre-reset");
        #2;
        rst_n = 1'b0;
        done  = 1'b0;
        #1;
        check("rst hold valid", 32'(valid), 0);
        check("rst hold bcd", 32'(bcd), 0);
        check("rst hold sign", 32'(sign), 0);
        check("rst hold busy", 32'(busy), 0);
        rst_n = 1'b1;
        last_sign = 1'b0;
        last_bcd  = 20'h0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (valid || busy) seen = 1'b1;
        end
        check("idle after hold reset", 32'(seen), 0);

        start_conv(16'h0001, 1'b0, 20'h00001, 1'b1);
        wait_result("p0001 after reset");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/product_bcd_reader.md
Name: product_bcd_reader

Overview:
- Consumer end of the multiplier controller's result interface: watches the done flag and captures the 16-bit signed product when it goes high.
- Converts the captured product to sign plus 5 BCD digits using a sequential double-dabble, one iteration per clock.
- Presents the digits with a valid flag, for the board display path that follows the multiplier.

Parameters:
- PROD_W, 16, product width in bits; also the number of conversion iterations.
- DIGITS, 5, number of BCD output digits; must cover 2^(PROD_W-1), so 5 for 16.

Ports:
- clk_out_i  input  1  system clock, the same divided clock that drives the multiplier controller.
- rst_ni  input  1  reset; one clock; asynchronous, active-low.
- done_i  input  1  controller done flag; level, stays high until the controller is reset.
- product_i  input  PROD_W  two's-complement product; stable whenever done_i=1.
- clear_i  input  1  synchronous request to drop the result and re-arm.
- sign_o  output  1  1 = negative result.
- bcd_o  output  4*DIGITS  magnitude in BCD; most significant digit in [4*DIGITS-1 -: 4].
- valid_o  output  1  bcd_o/sign_o hold a completed conversion.
- busy_o  output  1  conversion in progress.

Behaviour:
- Reset (rst_ni=0, takes effect immediately): state IDLE, sign_o=0, bcd_o=0, valid_o=0, busy_o=0, done_q=0, iteration count=0, working registers=0.
- Edge detect: done_q is a register of done_i, updated every cycle in every state. Start condition is done_i & ~done_q. A level-high done_i never retriggers.
- IDLE:
  - clear_i has priority; state stays IDLE and the edge is consumed.
  - Otherwise, on a start condition, go to CONVERT.
  - Load mag = product_i[15] ? (~product_i + 1) : product_i, treated as unsigned PROD_W; 0x8000 gives 32768.
  - Load sign_w = product_i[15], bcd_w = 0, count = 0.
  - Set busy_o=1 and valid_o=0 from the next cycle.
- CONVERT, each cycle:
  - Every bcd_w nibble >= 5 gets +3.
  - Then shift {bcd_w, mag} left by 1.
  - count increments.
  - When count reaches PROD_W-1 (16th iteration), the same edge performs the final iteration and:
    - registers bcd_o <= the final adjusted/shifted value;
    - sign_o <= sign_w;
    - valid_o <= 1, busy_o <= 0;
    - state goes to HOLD.
- Latency: the start edge is sampled at clock edge E; valid_o is high after edge E+16, i.e. 16 cycles in CONVERT.
- Output stability: bcd_o and sign_o change only on entry to HOLD. During CONVERT they keep the previous result; valid_o=0 then.
- CONVERT with clear_i=1: abort to IDLE, busy_o=0, valid_o stays 0, bcd_o/sign_o unchanged.
- HOLD: outputs frozen and valid_o=1. A done_i edge here is ignored (done_q still tracks). clear_i=1 sends the state to IDLE with valid_o=0; bcd_o/sign_o retain their values.
- Zero product: sign_o=0, bcd_o=0.
- Illegal state encoding goes to IDLE with valid_o=0 and busy_o=0.

Decomposition:
- Shared package (spm_pkg):
  - PROD_W and DIGITS defaults;
  - state type {IDLE, CONVERT, HOLD} as a 2-bit encoding;
  - BCD adjust threshold 5 and add constant 3;
  - iteration count width clog2(PROD_W+1).
- One combinational sub-module, dabble_step:
  - inputs {bcd, mag};
  - performs per-nibble add-3 plus the 1-bit left shift;
  - returns the next {bcd, mag}.
- The FSM, edge detect and output registers stay in product_bcd_reader.

Test Plan:
- Reset, then done_i 0->1 with product_i=0x4000 -> busy_o high for 16 cycles; valid_o=1 at E+16 with sign_o=0, bcd_o=0x16384.
- product_i=0xC080 (-16256) -> sign_o=1, bcd_o=0x16256. Then product_i=0xFFFF after clear_i and a new done_i pulse -> sign_o=1, bcd_o=0x00001.
- Boundaries, each after clear_i and a fresh done_i pulse:
  - product_i=0x8000 -> sign_o=1, bcd_o=0x32768;
  - product_i=0x0000 -> sign_o=0, bcd_o=0x00000.
- done_i held high through HOLD and after clear_i -> no second conversion; busy_o stays 0 and valid_o stays 0 after clear.
- clear_i asserted on the 8th CONVERT cycle with product_i=0x0019 -> IDLE, valid_o never rises, bcd_o keeps its prior value. A new 0->1 pulse then gives bcd_o=0x00025.
- rst_ni low for 1 ns mid-CONVERT and again in HOLD -> all outputs 0 immediately, without waiting for a clock; state IDLE after release.
